// File: rtl/rs_strobe_debounce.sv
// rs_strobe_debounce: debounces raw set/reset buttons into one-cycle active-low set0/rst0 strobes.
// Latency: strobe low DEBOUNCE_CYCLES cycles after the first pressed sample (+2 with RS_DEBOUNCE_SYNC_EN).
// Backpressure: none; a set fire that coincides with an rst fire waits in pending_set for one cycle.
// Build option: define RS_DEBOUNCE_SYNC_EN to put a 2-flop synchronizer in front of each channel.
module rs_strobe_debounce #(
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic system_clock,
    input  logic system_reset,
    input  logic btn_set,
    input  logic btn_rst,
    output logic set0,
    output logic rst0,
    output logic set_held,
    output logic rst_held
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PRESS   = 2'd1,
        S_HELD    = 2'd2,
        S_RELEASE = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    // With a one-sample debounce the PRESS/RELEASE states are skipped entirely.
    localparam logic             SINGLE  = (DEBOUNCE_CYCLES == 1);

    // Channel index 0 = set button, 1 = rst button.
    logic [1:0]       smp;
    state_e           state_q [2];
    state_e           state_d [2];
    logic [CNT_W-1:0] cnt_q   [2];
    logic [CNT_W-1:0] cnt_d   [2];
    logic [CNT_W-1:0] cnt_inc [2];
    logic [1:0]       fire;
    logic [1:0]       held;
    logic             want_set;
    logic             pending_set_q, pending_set_d;
    logic             set0_q, set0_d;
    logic             rst0_q, rst0_d;

`ifdef RS_DEBOUNCE_SYNC_EN
    logic [1:0] sync1_q, sync2_q;

    // Two-flop synchronizer per button; the FSM only ever sees the second stage.
    always_ff @(posedge system_clock) begin
        if (system_reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {btn_rst, btn_set};
            sync2_q <= sync1_q;
        end
    end

    assign smp = sync2_q;
`else
    assign smp = {btn_rst, btn_set};
`endif

    // Channel state and debounce counter registers.
    always_ff @(posedge system_clock) begin
        for (int i = 0; i < 2; i++) begin
            if (system_reset) begin
                state_q[i] <= S_IDLE;
                cnt_q[i]   <= '0;
            end else begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // Saturating increment so the counter can never wrap past CNT_MAX.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            cnt_inc[i] = (cnt_q[i] == CNT_MAX) ? cnt_q[i] : cnt_q[i] + CNT_ONE;
        end
    end

    // Next-state logic: a level change is accepted after CNT_MAX consecutive equal samples.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                S_IDLE: begin
                    if (smp[i]) begin
                        if (SINGLE) begin
                            state_d[i] = S_HELD;
                            cnt_d[i]   = CNT_MAX;
                        end else begin
                            state_d[i] = S_PRESS;
                            cnt_d[i]   = CNT_ONE;
                        end
                    end
                end
                S_PRESS: begin
                    if (smp[i]) begin
                        cnt_d[i] = cnt_inc[i];
                        if (cnt_inc[i] == CNT_MAX) begin
                            state_d[i] = S_HELD;
                        end
                    end else begin
                        state_d[i] = S_IDLE;
                        cnt_d[i]   = '0;
                    end
                end
                S_HELD: begin
                    if (!smp[i]) begin
                        if (SINGLE) begin
                            state_d[i] = S_IDLE;
                            cnt_d[i]   = '0;
                        end else begin
                            state_d[i] = S_RELEASE;
                            cnt_d[i]   = CNT_ONE;
                        end
                    end
                end
                S_RELEASE: begin
                    if (!smp[i]) begin
                        if (cnt_inc[i] == CNT_MAX) begin
                            state_d[i] = S_IDLE;
                            cnt_d[i]   = '0;
                        end else begin
                            cnt_d[i] = cnt_inc[i];
                        end
                    end else begin
                        state_d[i] = S_HELD;
                        cnt_d[i]   = '0;
                    end
                end
                default: begin
                    state_d[i] = S_IDLE;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    // Outputs: fire on entry to HELD from the not-held side; rst wins ties, set follows next cycle.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            held[i] = (state_q[i] == S_HELD) || (state_q[i] == S_RELEASE);
            fire[i] = ((state_q[i] == S_IDLE) || (state_q[i] == S_PRESS)) &&
                      (state_d[i] == S_HELD);
        end
        want_set      = pending_set_q | fire[0];
        set0_d        = 1'b1;
        rst0_d        = 1'b1;
        pending_set_d = 1'b0;
        if (fire[1]) begin
            rst0_d        = 1'b0;
            pending_set_d = want_set;
        end else if (want_set) begin
            set0_d = 1'b0;
        end
    end

    // Registered strobes and the deferred-set flag.
    always_ff @(posedge system_clock) begin
        if (system_reset) begin
            set0_q        <= 1'b1;
            rst0_q        <= 1'b1;
            pending_set_q <= 1'b0;
        end else begin
            set0_q        <= set0_d;
            rst0_q        <= rst0_d;
            pending_set_q <= pending_set_d;
        end
    end

    assign set0     = set0_q;
    assign rst0     = rst0_q;
    assign set_held = held[0];
    assign rst_held = held[1];

endmodule

// File: tb/tb_rs_strobe_debounce.sv
// Bench for rs_strobe_debounce at DEBOUNCE_CYCLES=4: vector table, corner-case sequences,
// and random button traffic against a sliding-window reference model.
module tb_rs_strobe_debounce;

    localparam int DC = 4;
`ifdef RS_DEBOUNCE_SYNC_EN
    localparam int SL = 2;
`else
    localparam int SL = 0;
`endif
    localparam int L  = DC + SL;
    localparam int NV = 34;

    logic clk = 1'b0;
    logic system_reset = 1'b1;
    logic btn_set = 1'b0;
    logic btn_rst = 1'b0;
    logic set0, rst0, set_held, rst_held;

    rs_strobe_debounce #(.DEBOUNCE_CYCLES(DC)) dut (
        .system_clock (clk),
        .system_reset (system_reset),
        .btn_set      (btn_set),
        .btn_rst      (btn_rst),
        .set0         (set0),
        .rst0         (rst0),
        .set_held     (set_held),
        .rst_held     (rst_held)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic rst;
        logic bs;
        logic br;
        logic e_set0;
        logic e_rst0;
        logic e_sh;
        logic e_rh;
    } vec_t;

    vec_t tbl [NV];

    int errors = 0;
    int checks = 0;
    int stepno = 0;

    // Reference model: a button level flips when the last DC samples all disagree with it.
    logic [DC-1:0] hist [2];
    logic [1:0]    lvl;
    logic [1:0]    p1, p2;
    logic [1:0]    fire_m;
    logic          pend_m;
    logic          e_set0, e_rst0;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step=%0d actual=%b expected=%b", name, stepno, act, exp);
        end
    endtask

    task automatic model_reset();
        hist[0] = '0;
        hist[1] = '0;
        lvl     = '0;
        p1      = '0;
        p2      = '0;
        pend_m  = 1'b0;
        e_set0  = 1'b1;
        e_rst0  = 1'b1;
    endtask

    task automatic step(input logic r, input logic bs, input logic br);
        logic [1:0] s;
        logic       want;
        system_reset = r;
        btn_set      = bs;
        btn_rst      = br;
        @(posedge clk);
        #1;
        stepno++;
        if (r) begin
            model_reset();
        end else begin
`ifdef RS_DEBOUNCE_SYNC_EN
            s  = p2;
            p2 = p1;
            p1 = {br, bs};
`else
            s  = {br, bs};
`endif
            for (int ch = 0; ch < 2; ch++) begin
                hist[ch]   = {hist[ch][DC-2:0], s[ch]};
                fire_m[ch] = 1'b0;
                if (lvl[ch] ? (hist[ch] == '0) : (hist[ch] == '1)) begin
                    lvl[ch]    = ~lvl[ch];
                    fire_m[ch] = lvl[ch];
                end
            end
            want = pend_m | fire_m[0];
            if (fire_m[1]) begin
                e_rst0 = 1'b0;
                e_set0 = 1'b1;
                pend_m = want;
            end else begin
                e_rst0 = 1'b1;
                e_set0 = ~want;
                pend_m = 1'b0;
            end
        end
        chk("never_both_low", ~(~set0 & ~rst0), 1'b1);
    endtask

    task automatic cmp_model();
        chk("rnd_set0", set0, e_set0);
        chk("rnd_rst0", rst0, e_rst0);
        chk("rnd_set_held", set_held, lvl[0]);
        chk("rnd_rst_held", rst_held, lvl[1]);
    endtask

    initial begin
        int  hs, hr;
        logic ls, lr, r;

        // Clean press of set (idx 1..16) and simultaneous press (idx 18..33), each after a reset row.
        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int k = 0; k < 16; k++) begin
            tbl[1 + k].rst    = 1'b0;
            tbl[1 + k].bs     = (k < 10);
            tbl[1 + k].br     = 1'b0;
            tbl[1 + k].e_set0 = (k != L - 1);
            tbl[1 + k].e_rst0 = 1'b1;
            tbl[1 + k].e_sh   = (k >= L - 1) && (k < 13 + SL);
            tbl[1 + k].e_rh   = 1'b0;
        end
        tbl[17] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int k = 0; k < 16; k++) begin
            tbl[18 + k].rst    = 1'b0;
            tbl[18 + k].bs     = (k < 10);
            tbl[18 + k].br     = (k < 10);
            tbl[18 + k].e_set0 = (k != L);
            tbl[18 + k].e_rst0 = (k != L - 1);
            tbl[18 + k].e_sh   = (k >= L - 1) && (k < 13 + SL);
            tbl[18 + k].e_rh   = (k >= L - 1) && (k < 13 + SL);
        end

        model_reset();

        for (int i = 0; i < NV; i++) begin
            step(tbl[i].rst, tbl[i].bs, tbl[i].br);
            chk("tbl_set0", set0, tbl[i].e_set0);
            chk("tbl_rst0", rst0, tbl[i].e_rst0);
            chk("tbl_set_held", set_held, tbl[i].e_sh);
            chk("tbl_rst_held", rst_held, tbl[i].e_rh);
        end

        // Bounce on press: 2-cycle burst, 1 low, then steady high.
        step(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 13; k++) begin
            step(1'b0, (k != 2), 1'b0);
            chk("bounce_set0", set0, (k != 6 + SL));
            chk("bounce_set_held", set_held, (k >= 6 + SL));
            chk("bounce_rst0", rst0, 1'b1);
        end

        // Long rst hold, release bounce, re-press.
        step(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 35; k++) begin
            logic b;
            b = (k < 20) || (k == 22) || (k >= 29);
            step(1'b0, 1'b0, b);
            chk("hold_rst0", rst0, !((k == L - 1) || (k == 32 + SL)));
            chk("hold_rst_held", rst_held,
                ((k >= L - 1) && (k < 26 + SL)) || (k >= 32 + SL));
            chk("hold_set0", set0, 1'b1);
        end

        // Reset while PRESS is counting, button held throughout.
        step(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 13; k++) begin
            step((k == 2), 1'b1, 1'b0);
            chk("midrst_set0", set0, (k != 6 + SL));
            chk("midrst_set_held", set_held, (k >= 6 + SL));
        end

        // Random bouncy traffic against the reference model.
        step(1'b1, 1'b0, 1'b0);
        hs = 0;
        hr = 0;
        ls = 1'b0;
        lr = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (hs == 0) begin
                ls = 1'($urandom_range(0, 1));
                hs = $urandom_range(1, 8);
            end
            if (hr == 0) begin
                lr = 1'($urandom_range(0, 1));
                hr = $urandom_range(1, 8);
            end
            hs--;
            hr--;
            r = ($urandom_range(0, 299) == 0);
            step(r, ls, lr);
            cmp_model();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
